sram_req_scheduler: RTL and testbench

//  Upstream request front end for the SRAM controller. Buffers host read/write

---
 rtl/sram_req_scheduler_if.sv | 34 +++
 rtl/sram_req_scheduler.sv | 140 ++++++++++++++
 tb/tb_sram_req_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_scheduler_if.sv
// Host request/response channel and SRAM-controller strobes of the request scheduler.
// master = host plus controller side, slave = scheduler.
interface sram_req_scheduler_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  ctl_cs;
  logic                  ctl_we;
  logic                  ctl_oe;
  logic [ADDR_WIDTH-1:0] ctl_address;
  logic [DATA_WIDTH-1:0] ctl_data_o;
  logic                  ctl_data_oe;
  logic [DATA_WIDTH-1:0] ctl_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ctl_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ctl_cs, ctl_we, ctl_oe,
    input  ctl_address, ctl_data_o, ctl_data_oe, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ctl_rdata,
    output req_ready, rsp_valid, rsp_rdata, ctl_cs, ctl_we, ctl_oe,
    output ctl_address, ctl_data_o, ctl_data_oe, busy
  );
endinterface

// File: rtl/sram_req_scheduler.sv
// Request FIFO plus a 4-state sequencer that issues one SRAM access per
// 3-cycle controller window and returns read data as a single-cycle pulse.
module sram_req_scheduler #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  sram_req_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD1 = 2'd2,
    S_HOLD2 = 2'd3
  } state_t;

  logic [ENT_W-1:0]      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  state_t                r_state;
  logic                  r_cmd_we;
  logic                  r_cs;
  logic                  r_we;
  logic                  r_oe;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data_o;
  logic                  r_data_oe;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_we;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;

  assign w_ready = (r_count != FULL_CNT);
  assign w_push  = bus.req_valid && w_ready;
  // Only entries already counted are visible here, so a same-edge push is never bypassed.
  assign w_pop   = ((r_state == S_IDLE) || (r_state == S_HOLD2)) && (r_count != {CNT_W{1'b0}});
  assign {w_head_we, w_head_addr, w_head_wdata} = r_fifo[r_rd_ptr];

  // Request FIFO storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= {ENT_W{1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {bus.req_we, bus.req_addr, bus.req_wdata};
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Access sequencer with registered controller strobes and read-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_we    <= 1'b0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_data_o    <= {DATA_WIDTH{1'b0}};
      r_data_oe   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_WIDTH{1'b0}};
    end else begin
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE:  r_state <= S_IDLE;
        S_ISSUE: r_state <= S_HOLD1;
        S_HOLD1: r_state <= S_HOLD2;
        S_HOLD2: begin
          // Controller read data is valid while we sit in HOLD2.
          if (!r_cmd_we) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= bus.ctl_rdata;
          end
          r_state   <= S_IDLE;
          r_addr    <= {ADDR_WIDTH{1'b0}};
          r_data_o  <= {DATA_WIDTH{1'b0}};
          r_data_oe <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_addr    <= {ADDR_WIDTH{1'b0}};
          r_data_o  <= {DATA_WIDTH{1'b0}};
          r_data_oe <= 1'b0;
        end
      endcase
      if (w_pop) begin
        r_state   <= S_ISSUE;
        r_cmd_we  <= w_head_we;
        r_cs      <= 1'b1;
        r_we      <= w_head_we;
        r_oe      <= !w_head_we;
        r_addr    <= w_head_addr;
        r_data_o  <= w_head_we ? w_head_wdata : {DATA_WIDTH{1'b0}};
        r_data_oe <= w_head_we;
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.busy        = (r_state != S_IDLE) || (r_count != {CNT_W{1'b0}});
  assign bus.ctl_cs      = r_cs;
  assign bus.ctl_we      = r_we;
  assign bus.ctl_oe      = r_oe;
  assign bus.ctl_address = r_addr;
  assign bus.ctl_data_o  = r_data_o;
  assign bus.ctl_data_oe = r_data_oe;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
endmodule

// File: tb/tb_sram_req_scheduler.sv
// Randomized bench for sram_req_scheduler: an in-order request/response
// reference queue plus a small SRAM-controller responder with its own memory.
module tb_sram_req_scheduler;
  localparam int AW = 16;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  sram_req_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  sram_req_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: expected issue order and expected read data, in request order.
  logic [DW-1:0] refmem [0:65535];
  logic [DW-1:0] cmem   [0:65535];
  req_t          exp_q[$];
  logic [DW-1:0] exp_rsp[$];

  function automatic void model_accept(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.we = we; r.addr = a; r.data = d;
    exp_q.push_back(r);
    if (we) refmem[a] = d;
    else exp_rsp.push_back(refmem[a]);
  endfunction

  // Controller responder: writes land at the cs edge, read data appears one edge later.
  logic          rd_pend;
  logic [AW-1:0] rd_addr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend       <= 1'b0;
      rd_addr       <= '0;
      bus.ctl_rdata <= '0;
    end else begin
      bus.ctl_rdata <= rd_pend ? cmem[rd_addr] : 8'($urandom);
      rd_pend       <= 1'b0;
      if (bus.ctl_cs) begin
        if (bus.ctl_we) cmem[bus.ctl_address] <= bus.ctl_data_o;
        else begin
          rd_pend <= 1'b1;
          rd_addr <= bus.ctl_address;
        end
      end
    end
  end

  // Scoreboard on the controller strobes and response channel
  req_t          cur = '0;
  int            phase = 0;
  int            last_cs = 0;
  bit            last_cs_valid = 1'b0;
  bit            have_rsp = 1'b0;
  logic [DW-1:0] last_rsp = '0;
  always @(negedge clk) begin
    logic [27:0]   got_v, exp_v;
    logic [DW-1:0] e;
    if (!reset) begin
      got_v = {bus.ctl_cs, bus.ctl_we, bus.ctl_oe, bus.ctl_data_oe, bus.ctl_address, bus.ctl_data_o};
      if (bus.ctl_cs) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL cs_unexpected: cs pulse at addr %h with no pending request", bus.ctl_address);
        end else begin
          cur = exp_q.pop_front();
          exp_v = {1'b1, cur.we, !cur.we, cur.we, cur.addr, cur.we ? cur.data : 8'h00};
          if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL cs_fields: got %h expected %h", got_v, exp_v);
          end
        end
        if (last_cs_valid) begin
          n_cmp++;
          if (cyc - last_cs < 3) begin
            n_fail++;
            $display("FAIL cs_spacing: got %0d cycles expected >= 3", cyc - last_cs);
          end
        end
        last_cs = cyc; last_cs_valid = 1'b1; phase = 1;
      end else if (phase == 1 || phase == 2) begin
        n_cmp++;
        exp_v = {3'b000, cur.we, cur.addr, cur.we ? cur.data : 8'h00};
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL hold_fields: got %h expected %h", got_v, exp_v);
        end
        phase++;
      end else begin
        phase = 0;
      end
      if (bus.rsp_valid) begin
        n_cmp++;
        if (exp_rsp.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_spurious: got rsp_valid with data %h expected none", bus.rsp_rdata);
        end else begin
          e = exp_rsp.pop_front();
          if (bus.rsp_rdata !== e) begin
            n_fail++;
            $display("FAIL rsp_data: got %h expected %h", bus.rsp_rdata, e);
          end
        end
        have_rsp = 1'b1; last_rsp = bus.rsp_rdata;
      end else if (have_rsp) begin
        n_cmp++;
        if (bus.rsp_rdata !== last_rsp) begin
          n_fail++;
          $display("FAIL rsp_hold: got %h expected %h", bus.rsp_rdata, last_rsp);
        end
      end
    end
  end

  function automatic logic [36:0] obs();
    return {bus.ctl_cs, bus.ctl_we, bus.ctl_oe, bus.ctl_data_oe, bus.ctl_address,
            bus.ctl_data_o, bus.rsp_valid, bus.rsp_rdata};
  endfunction

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
    int t;
    t = 0; acc = -1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk); t++;
    end
    if (!bus.req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: req_ready got 0 expected 1 within 50 cycles");
    end else begin
      acc = cyc + 1;
      model_accept(we, a, d);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.busy && t < 100) begin
      @(negedge clk); t++;
    end
    if (bus.busy) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy got 1 expected 0 within 100 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic flush_model_on_reset();
    reset = 1'b1;
    exp_q.delete(); exp_rsp.delete();
    phase = 0; last_cs_valid = 1'b0; have_rsp = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({obs(), bus.busy} !== 38'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {obs(), bus.busy});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_ready: got ready/busy %b expected 10", {bus.req_ready, bus.busy});
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    int acc;
    logic [36:0] exp_v;
    send(1'b1, 16'h1234, 8'hA5, acc);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = {(k == 1), (k == 1), 1'b0, (k <= 3), (k <= 3) ? 16'h1234 : 16'h0000,
               (k <= 3) ? 8'hA5 : 8'h00, 1'b0, 8'h00};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_fail++; $display("FAIL write_k%0d: got %h expected %h", k, obs(), exp_v);
      end
    end
    wait_idle();
  endtask

  task automatic test_read();
    int acc;
    logic [36:0] exp_v;
    cmem[16'h0010] = 8'h5C; refmem[16'h0010] = 8'h5C;
    send(1'b0, 16'h0010, 8'h00, acc);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = {(k == 1), 1'b0, (k == 1), 1'b0, (k <= 3) ? 16'h0010 : 16'h0000,
               8'h00, (k == 4), (k >= 4) ? 8'h5C : 8'h00};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_fail++; $display("FAIL read_k%0d: got %h expected %h", k, obs(), exp_v);
      end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int accs[6];
    int cs_cyc[$];
    bit ready_low;
    ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b1, 16'h0100 + 16'(i), 8'($urandom), accs[i]);
      end
      begin
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (bus.ctl_cs) cs_cyc.push_back(cyc);
          if (!bus.req_ready) ready_low = 1'b1;
        end
      end
    join
    n_cmp++;
    if (accs[5] - accs[0] != 5) begin
      n_fail++; $display("FAIL b2b_accept: got span %0d expected 5", accs[5] - accs[0]);
    end
    n_cmp++;
    if (ready_low !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_drop: got %b expected 1", ready_low);
    end
    n_cmp++;
    if (cs_cyc.size() != 6) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d expected 6", cs_cyc.size());
    end else begin
      n_cmp++;
      if (cs_cyc[0] != accs[0] + 1) begin
        n_fail++; $display("FAIL b2b_first_cs: got cycle %0d expected %0d", cs_cyc[0], accs[0] + 1);
      end
      for (int i = 1; i < 6; i++) begin
        n_cmp++;
        if (cs_cyc[i] - cs_cyc[i-1] != 3) begin
          n_fail++; $display("FAIL b2b_gap%0d: got %0d expected 3", i, cs_cyc[i] - cs_cyc[i-1]);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_full_pop();
    int acc0, acc, dummy;
    send(1'b1, 16'h0200, 8'($urandom), acc0);
    for (int i = 1; i < 6; i++) send(1'b1, 16'h0200 + 16'(i), 8'($urandom), dummy);
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ready: got %b expected 0", bus.req_ready);
    end
    send(1'b1, 16'h0206, 8'($urandom), acc);
    n_cmp++;
    if (acc != acc0 + 8) begin
      n_fail++; $display("FAIL full_pop_accept: got edge %0d expected %0d", acc, acc0 + 8);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int acc, t;
    bit saw;
    logic [DW-1:0] e;
    send(1'b1, 16'h0300, 8'($urandom), acc);
    repeat (2) @(negedge clk);
    flush_model_on_reset();
    #1;
    n_cmp++;
    if ({bus.ctl_data_oe, bus.ctl_data_o} !== 9'd0) begin
      n_fail++; $display("FAIL reset_async_doe: got %h expected 0", {bus.ctl_data_oe, bus.ctl_data_o});
    end
    @(negedge clk);
    reset = 1'b0;
    send(1'b0, 16'h0310, 8'h00, acc);
    repeat (2) @(negedge clk);
    flush_model_on_reset();
    #1;
    n_cmp++;
    if ({bus.ctl_cs, bus.ctl_we, bus.ctl_oe, bus.ctl_address, bus.ctl_data_o, bus.ctl_data_oe,
         bus.rsp_valid, bus.req_ready, bus.busy} !== 31'd2) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected 2",
        {bus.ctl_cs, bus.ctl_we, bus.ctl_oe, bus.ctl_address, bus.ctl_data_o, bus.ctl_data_oe,
         bus.rsp_valid, bus.req_ready, bus.busy});
    end
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.ctl_cs) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_fail++; $display("FAIL reset_dropped: got activity %b expected 0", saw);
    end
    e = refmem[16'h0320];
    send(1'b0, 16'h0320, 8'h00, acc);
    t = 0;
    while (!bus.rsp_valid && t < 12) begin
      @(negedge clk); t++;
    end
    n_cmp++;
    if (!bus.rsp_valid || bus.rsp_rdata !== e) begin
      n_fail++; $display("FAIL reset_recover: got valid %b data %h expected 1 %h", bus.rsp_valid, bus.rsp_rdata, e);
    end
    wait_idle();
  endtask

  task automatic test_mixed();
    int acc, t;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        send(1'($urandom), 16'(i), 8'($urandom), acc);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    t = 0;
    while (bus.busy && t < 100) begin
      @(negedge clk); t++;
    end
    n_cmp++;
    if (bus.busy) begin
      n_fail++; $display("FAIL mixed_busy_timeout: busy got 1 expected 0");
    end else if (cyc != last_cs + 3) begin
      n_fail++; $display("FAIL mixed_busy_fall: got cycle %0d expected %0d", cyc, last_cs + 3);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || exp_rsp.size() != 0) begin
      n_fail++; $display("FAIL mixed_drain: got %0d/%0d pending expected 0/0", exp_q.size(), exp_rsp.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      cmem[i]   = 8'($urandom);
      refmem[i] = cmem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    test_mixed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
